// File: rtl/apb_master_txn_engine.sv
// APB3/APB4 master: queued commands become APB transfers with address-decoded PSEL,
// a wait-state timeout and a held response. Define APB_MASTER_TXN_STATS_EN for statistics outputs.
module apb_master_txn_engine #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_SLAVES     = 4,
   parameter int CMD_DEPTH      = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      pclk,
   input  logic                      preset,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic                      cmd_write,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
   input  logic [2:0]                cmd_prot,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic                      rsp_slverr,
   output logic                      rsp_timeout,
   output logic [ADDR_WIDTH-1:0]     paddr,
   output logic [NUM_SLAVES-1:0]     psel,
   output logic                      penable,
   output logic                      pwrite,
   output logic [DATA_WIDTH-1:0]     pwdata,
   output logic [DATA_WIDTH/8-1:0]   pstrb,
   output logic [2:0]                pprot,
   input  logic [DATA_WIDTH-1:0]     prdata,
   input  logic                      pready,
   input  logic                      pslverr
`ifdef APB_MASTER_TXN_STATS_EN
   ,
   output logic [15:0]               stat_wr_cnt,
   output logic [15:0]               stat_rd_cnt,
   output logic [15:0]               stat_err_cnt,
   output logic [15:0]               stat_wait_max
`endif
);

   localparam int PW       = $clog2(CMD_DEPTH);
   localparam int SW       = DATA_WIDTH / 8;
   localparam int SEL_BITS = $clog2(NUM_SLAVES);
   localparam int SEL_W    = (SEL_BITS == 0) ? 1 : SEL_BITS;
   localparam logic [15:0] WAIT_LIM = (TIMEOUT_CYCLES > 0) ? 16'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   state_t state, state_nxt;

   logic [ADDR_WIDTH-1:0] fifo_addr  [CMD_DEPTH];
   logic                  fifo_write [CMD_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_wdata [CMD_DEPTH];
   logic [SW-1:0]         fifo_strb  [CMD_DEPTH];
   logic [2:0]            fifo_prot  [CMD_DEPTH];

   logic [PW:0] wr_ptr, rd_ptr;
   logic        full, empty, push, pop;

   logic [ADDR_WIDTH-1:0] head_addr;
   logic                  head_write;
   logic [DATA_WIDTH-1:0] head_wdata;
   logic [SW-1:0]         head_strb;
   logic [2:0]            head_prot;

   logic [SEL_W-1:0]      sel_idx;
   logic                  dec_err;
   logic [NUM_SLAVES-1:0] psel_dec;

   logic [15:0] wait_cnt;
   logic        start, done, abort, dec_fail;

   // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign cmd_ready = !full;
   assign push      = cmd_valid && cmd_ready;

   assign head_addr  = fifo_addr[rd_ptr[PW-1:0]];
   assign head_write = fifo_write[rd_ptr[PW-1:0]];
   assign head_wdata = fifo_wdata[rd_ptr[PW-1:0]];
   assign head_strb  = fifo_strb[rd_ptr[PW-1:0]];
   assign head_prot  = fifo_prot[rd_ptr[PW-1:0]];

   always_ff @(posedge pclk) begin
      if (push) begin
         fifo_addr[wr_ptr[PW-1:0]]  <= cmd_addr;
         fifo_write[wr_ptr[PW-1:0]] <= cmd_write;
         fifo_wdata[wr_ptr[PW-1:0]] <= cmd_wdata;
         fifo_strb[wr_ptr[PW-1:0]]  <= cmd_strb;
         fifo_prot[wr_ptr[PW-1:0]]  <= cmd_prot;
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   generate
      if (SEL_BITS == 0) begin : g_single
         assign sel_idx = '0;
         assign dec_err = 1'b0;
      end else begin : g_multi
         assign sel_idx = head_addr[ADDR_WIDTH-1 -: SEL_W];
         assign dec_err = ({1'b0, sel_idx} >= (SEL_W + 1)'(NUM_SLAVES));
      end
   endgenerate

   assign psel_dec = (NUM_SLAVES)'(1) << sel_idx;

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      start     = 1'b0;
      done      = 1'b0;
      abort     = 1'b0;
      dec_fail  = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && !rsp_valid) begin
               pop = 1'b1;
               if (dec_err) begin
                  dec_fail = 1'b1;
               end else begin
                  start     = 1'b1;
                  state_nxt = SETUP;
               end
            end
         end
         SETUP: state_nxt = ACCESS;
         ACCESS: begin
            // pready wins over a timeout landing on the same edge
            if (pready) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end else if (TIMEOUT_CYCLES > 0 && wait_cnt == WAIT_LIM) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state    <= IDLE;
         psel     <= '0;
         penable  <= 1'b0;
         paddr    <= '0;
         pwrite   <= 1'b0;
         pwdata   <= '0;
         pstrb    <= '0;
         pprot    <= '0;
         wait_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (start) begin
            psel     <= psel_dec;
            paddr    <= head_addr;
            pwrite   <= head_write;
            pwdata   <= head_wdata;
            pstrb    <= head_write ? head_strb : '0;
            pprot    <= head_prot;
            wait_cnt <= '0;
         end
         if (state == SETUP) penable <= 1'b1;
         if (done || abort) begin
            psel    <= '0;
            penable <= 1'b0;
            pwdata  <= '0;
            pstrb   <= '0;
         end
         if (state == ACCESS && !pready && wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_slverr  <= 1'b0;
         rsp_timeout <= 1'b0;
      end else if (done) begin
         rsp_valid   <= 1'b1;
         rsp_rdata   <= pwrite ? '0 : prdata;
         rsp_slverr  <= pslverr;
         rsp_timeout <= 1'b0;
      end else if (abort || dec_fail) begin
         rsp_valid   <= 1'b1;
         rsp_rdata   <= '0;
         rsp_slverr  <= 1'b1;
         rsp_timeout <= abort;
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

`ifdef APB_MASTER_TXN_STATS_EN
   logic rsp_load, rsp_is_write, rsp_err;

   assign rsp_load     = done || abort || dec_fail;
   assign rsp_is_write = dec_fail ? head_write : pwrite;
   assign rsp_err      = dec_fail || abort || (done && pslverr);

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         stat_wr_cnt   <= '0;
         stat_rd_cnt   <= '0;
         stat_err_cnt  <= '0;
         stat_wait_max <= '0;
      end else begin
         if (rsp_load && rsp_is_write && stat_wr_cnt != '1)   stat_wr_cnt  <= stat_wr_cnt + 1'b1;
         if (rsp_load && !rsp_is_write && stat_rd_cnt != '1)  stat_rd_cnt  <= stat_rd_cnt + 1'b1;
         if (rsp_err && stat_err_cnt != '1)                   stat_err_cnt <= stat_err_cnt + 1'b1;
         if (state == ACCESS && !pready && wait_cnt != '1 && (wait_cnt + 1'b1) > stat_wait_max)
            stat_wait_max <= wait_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_apb_master_txn_engine.sv
// Directed self-checking bench for apb_master_txn_engine (4-slave default instance plus a 3-slave decode instance).
module tb_apb_master_txn_engine;

   logic        pclk = 1'b0;
   logic        preset = 1'b1;
   always #5 pclk = ~pclk;

   // Default instance signals
   logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
   logic [31:0] cmd_addr = '0, cmd_wdata = '0;
   logic [3:0]  cmd_strb = '0;
   logic [2:0]  cmd_prot = '0;
   logic        pready = 1'b0, pslverr = 1'b0, prdata_auto = 1'b0;
   logic [31:0] prdata_v = '0;
   wire  [31:0] prdata;
   wire         cmd_ready, rsp_valid, rsp_slverr, rsp_timeout, penable, pwrite;
   wire  [31:0] rsp_rdata, paddr, pwdata;
   wire  [3:0]  psel, pstrb;
   wire  [2:0]  pprot;

   assign prdata = prdata_auto ? ~paddr : prdata_v;

   apb_master_txn_engine dut (
      .pclk(pclk), .preset(preset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_write(cmd_write),
      .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
      .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   // Three-slave instance for decode-error coverage
   logic        cmd_valid3 = 1'b0, rsp_ready3 = 1'b0;
   logic [31:0] cmd_addr3 = '0;
   logic        cmd_write3 = 1'b0, pready3 = 1'b1, pslverr3 = 1'b0;
   logic [31:0] cmd_wdata3 = '0, prdata3 = '0;
   logic [3:0]  cmd_strb3 = '0;
   logic [2:0]  cmd_prot3 = '0;
   wire         cmd_ready3, rsp_valid3, rsp_slverr3, rsp_timeout3, penable3, pwrite3;
   wire  [31:0] rsp_rdata3, paddr3, pwdata3;
   wire  [2:0]  psel3, pprot3;
   wire  [3:0]  pstrb3;

   apb_master_txn_engine #(.NUM_SLAVES(3)) dut3 (
      .pclk(pclk), .preset(preset),
      .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_addr(cmd_addr3), .cmd_write(cmd_write3),
      .cmd_wdata(cmd_wdata3), .cmd_strb(cmd_strb3), .cmd_prot(cmd_prot3),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3),
      .rsp_slverr(rsp_slverr3), .rsp_timeout(rsp_timeout3),
      .paddr(paddr3), .psel(psel3), .penable(penable3), .pwrite(pwrite3), .pwdata(pwdata3),
      .pstrb(pstrb3), .pprot(pprot3), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
   );

   int checks = 0;
   int failures = 0;

   // Log of every SETUP phase seen on the default instance
   int          xfer_cnt = 0;
   logic [31:0] xfer_log [64];
   always @(posedge pclk) begin
      if (|psel && !penable) begin
         xfer_log[xfer_cnt % 64] <= paddr;
         xfer_cnt <= xfer_cnt + 1;
      end
   end

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic set_cmd(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] p);
      cmd_addr = a; cmd_write = w; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
   endtask

   task automatic test_reset();
      preset = 1'b1;
      repeat (2) @(posedge pclk);
      #1;
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (psel !== 4'b0000 || penable !== 1'b0) begin failures++; $display("FAIL rst_psel_penable got=%b/%b exp=0000/0", psel, penable); end
      checks++; if (paddr !== 32'h0 || pwdata !== 32'h0 || pstrb !== 4'h0 || pwrite !== 1'b0 || pprot !== 3'b0)
         begin failures++; $display("FAIL rst_bus got=%h/%h/%h/%b/%h exp=all zero", paddr, pwdata, pstrb, pwrite, pprot); end
      checks++; if (rsp_rdata !== 32'h0 || rsp_slverr !== 1'b0 || rsp_timeout !== 1'b0)
         begin failures++; $display("FAIL rst_rsp got=%h/%b/%b exp=0/0/0", rsp_rdata, rsp_slverr, rsp_timeout); end
      preset = 1'b0;
      tick();
   endtask

   task automatic test_write();
      pready = 1'b1;
      set_cmd(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010);
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      checks++; if (psel !== 4'b0000) begin failures++; $display("FAIL wr_pre_psel got=%b exp=0000", psel); end
      tick();
      checks++; if (psel !== 4'b0001 || penable !== 1'b0) begin failures++; $display("FAIL wr_setup got=%b/%b exp=0001/0", psel, penable); end
      checks++; if (paddr !== 32'h10 || pwrite !== 1'b1 || pwdata !== 32'hDEAD_BEEF || pstrb !== 4'hF || pprot !== 3'b010)
         begin failures++; $display("FAIL wr_setup_bus got=%h/%b/%h/%h/%h exp=10/1/deadbeef/f/2", paddr, pwrite, pwdata, pstrb, pprot); end
      tick();
      checks++; if (psel !== 4'b0001 || penable !== 1'b1) begin failures++; $display("FAIL wr_access got=%b/%b exp=0001/1", psel, penable); end
      tick();
      checks++; if (psel !== 4'b0000 || penable !== 1'b0) begin failures++; $display("FAIL wr_release got=%b/%b exp=0000/0", psel, penable); end
      checks++; if (rsp_valid !== 1'b1 || rsp_slverr !== 1'b0 || rsp_rdata !== 32'h0 || rsp_timeout !== 1'b0)
         begin failures++; $display("FAIL wr_rsp got=%b/%b/%h/%b exp=1/0/0/0", rsp_valid, rsp_slverr, rsp_rdata, rsp_timeout); end
      checks++; if (pwdata !== 32'h0 || pstrb !== 4'h0 || paddr !== 32'h10 || pwrite !== 1'b1 || pprot !== 3'b010)
         begin failures++; $display("FAIL wr_idle_bus got=%h/%h/%h/%b/%h exp=0/0/10/1/2", pwdata, pstrb, paddr, pwrite, pprot); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_rsp_clear got=%b exp=0", rsp_valid); end
   endtask

   task automatic test_read_wait();
      pready = 1'b0; pslverr = 1'b0; prdata_v = 32'h1234_5678;
      set_cmd(32'h4000_0004, 1'b0, 32'h5555_AAAA, 4'hF, 3'b000);
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      checks++; if (psel !== 4'b0010 || pstrb !== 4'h0 || pwrite !== 1'b0)
         begin failures++; $display("FAIL rd_setup got=%b/%h/%b exp=0010/0/0", psel, pstrb, pwrite); end
      tick();
      checks++; if (penable !== 1'b1) begin failures++; $display("FAIL rd_access1 got=%b exp=1", penable); end
      tick();
      tick();
      checks++; if (penable !== 1'b1 || psel !== 4'b0010 || rsp_valid !== 1'b0)
         begin failures++; $display("FAIL rd_access3 got=%b/%b/%b exp=1/0010/0", penable, psel, rsp_valid); end
      pready = 1'b1;
      tick();
      pready = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || rsp_slverr !== 1'b0 || psel !== 4'b0000)
         begin failures++; $display("FAIL rd_rsp got=%b/%h/%b/%b exp=1/12345678/0/0000", rsp_valid, rsp_rdata, rsp_slverr, psel); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic run_long_access(input logic finish_ready);
      logic en_ok;
      en_ok = 1'b1;
      set_cmd(32'h8000_0008, 1'b0, 32'h0, 4'h0, 3'b001);
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 15; i++) begin
         if (penable !== 1'b1) en_ok = 1'b0;
         tick();
      end
      checks++; if (en_ok !== 1'b1 || penable !== 1'b1)
         begin failures++; $display("FAIL to_held got=%b/%b exp=1/1 (ready=%b)", en_ok, penable, finish_ready); end
      pready = finish_ready;
      tick();
      pready = 1'b0;
   endtask

   task automatic test_timeout();
      // pready arriving on the 16th ACCESS edge is a normal completion
      prdata_v = 32'h0BAD_F00D; pslverr = 1'b1;
      run_long_access(1'b1);
      pslverr = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_slverr !== 1'b1 || rsp_rdata !== 32'h0BAD_F00D)
         begin failures++; $display("FAIL to_boundary got=%b/%b/%b/%h exp=1/0/1/0badf00d", rsp_valid, rsp_timeout, rsp_slverr, rsp_rdata); end
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
      run_long_access(1'b0);
      checks++; if (psel !== 4'b0000 || penable !== 1'b0) begin failures++; $display("FAIL to_release got=%b/%b exp=0000/0", psel, penable); end
      checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_slverr !== 1'b1 || rsp_rdata !== 32'h0)
         begin failures++; $display("FAIL to_rsp got=%b/%b/%b/%h exp=1/1/1/0", rsp_valid, rsp_timeout, rsp_slverr, rsp_rdata); end
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
   endtask

   task automatic test_decode();
      cmd_addr3 = 32'hC000_0000; cmd_valid3 = 1'b1;
      tick();
      cmd_valid3 = 1'b0;
      checks++; if (rsp_valid3 !== 1'b0 || psel3 !== 3'b000) begin failures++; $display("FAIL dec_pre got=%b/%b exp=0/000", rsp_valid3, psel3); end
      tick();
      checks++; if (rsp_valid3 !== 1'b1 || rsp_slverr3 !== 1'b1 || rsp_timeout3 !== 1'b0 || rsp_rdata3 !== 32'h0 || psel3 !== 3'b000)
         begin failures++; $display("FAIL dec_err got=%b/%b/%b/%h/%b exp=1/1/0/0/000", rsp_valid3, rsp_slverr3, rsp_timeout3, rsp_rdata3, psel3); end
      rsp_ready3 = 1'b1; tick(); rsp_ready3 = 1'b0;
      checks++; if (rsp_valid3 !== 1'b0 || psel3 !== 3'b000) begin failures++; $display("FAIL dec_after got=%b/%b exp=0/000", rsp_valid3, psel3); end
      cmd_addr3 = 32'h8000_0000; cmd_valid3 = 1'b1;
      tick();
      cmd_valid3 = 1'b0;
      tick();
      checks++; if (psel3 !== 3'b100) begin failures++; $display("FAIL dec_top_psel got=%b exp=100", psel3); end
      tick();
      tick();
      checks++; if (rsp_valid3 !== 1'b1 || rsp_slverr3 !== 1'b0) begin failures++; $display("FAIL dec_top_rsp got=%b/%b exp=1/0", rsp_valid3, rsp_slverr3); end
      rsp_ready3 = 1'b1; tick(); rsp_ready3 = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] addr_tab [5];
      int base, got;
      addr_tab[0] = 32'h0000_0100; addr_tab[1] = 32'h4000_0200; addr_tab[2] = 32'h8000_0300;
      addr_tab[3] = 32'hC000_0400; addr_tab[4] = 32'h0000_0500;
      base = xfer_cnt;
      prdata_auto = 1'b1; pready = 1'b1; rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_cmd(addr_tab[i], 1'b0, 32'h0, 4'h0, 3'b000);
         cmd_valid = 1'b1;
         checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d got=%b exp=1", i, cmd_ready); end
         tick();
      end
      cmd_valid = 1'b0;
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_full got=%b exp=0", cmd_ready); end
      repeat (6) tick();
      checks++; if (xfer_cnt - base !== 1 || rsp_valid !== 1'b1)
         begin failures++; $display("FAIL b2b_stall got=%0d/%b exp=1/1", xfer_cnt - base, rsp_valid); end
      rsp_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 80 && got < 5; c++) begin
         if (rsp_valid === 1'b1) begin
            checks++; if (rsp_rdata !== ~addr_tab[got])
               begin failures++; $display("FAIL b2b_rdata_%0d got=%h exp=%h", got, rsp_rdata, ~addr_tab[got]); end
            got++;
         end
         tick();
      end
      rsp_ready = 1'b0;
      prdata_auto = 1'b0;
      checks++; if (got != 5 || xfer_cnt - base !== 5)
         begin failures++; $display("FAIL b2b_count got=%0d/%0d exp=5/5", got, xfer_cnt - base); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (xfer_log[(base + i) % 64] !== addr_tab[i])
            begin failures++; $display("FAIL b2b_order_%0d got=%h exp=%h", i, xfer_log[(base + i) % 64], addr_tab[i]); end
      end
   endtask

   task automatic test_reset_mid_access();
      pready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_cmd(32'h4000_0000 + 32'(i), 1'b1, 32'h1111_0000 + 32'(i), 4'h3, 3'b000);
         cmd_valid = 1'b1;
         tick();
      end
      cmd_valid = 1'b0;
      checks++; if (penable !== 1'b1 || cmd_ready !== 1'b0)
         begin failures++; $display("FAIL mid_pre got=%b/%b exp=1/0", penable, cmd_ready); end
      #2;
      preset = 1'b1;
      #1;
      checks++; if (psel !== 4'b0000 || penable !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
         begin failures++; $display("FAIL mid_async got=%b/%b/%b/%b exp=0000/0/1/0", psel, penable, cmd_ready, rsp_valid); end
      tick();
      preset = 1'b0;
      pready = 1'b1;
      repeat (4) tick();
      checks++; if (psel !== 4'b0000 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
         begin failures++; $display("FAIL mid_flushed got=%b/%b/%b exp=0000/0/1", psel, rsp_valid, cmd_ready); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write();
      test_read_wait();
      test_decode();
      test_timeout();
      test_back_to_back();
      test_reset_mid_access();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
